// File: rtl/mem_rmw_sequencer_if.sv
// RAM port of the read-modify-write sequencer: registered address/write side, synchronous read data back.
interface mem_rmw_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/mem_rmw_sequencer.sv
// Read-modify-write address sweep over a single-cycle-read RAM, one state per step edge or per clock.
// Optional VERIFY readback with sticky error when MEM_RMW_VERIFY_EN is defined.
module mem_rmw_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int INC        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_i,
  input  logic                  auto_run_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] end_addr_i,
  input  logic [1:0]            mode_i,
  mem_rmw_sequencer_if.master   mem,
  output logic [ADDR_WIDTH-1:0] disp_addr_o,
  output logic [DATA_WIDTH-1:0] disp_rdata_o,
  output logic [DATA_WIDTH-1:0] disp_wdata_o,
  output logic [2:0]            state_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_MODIFY = 3'd3,
    S_WRITE  = 3'd4,
    S_VERIFY = 3'd5,
    S_NEXT   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [DATA_WIDTH-1:0] INC_W = DATA_WIDTH'(INC);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [ADDR_WIDTH-1:0] end_addr_q;
  logic [ADDR_WIDTH-1:0] next_addr_d;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] wr_q;
  logic [DATA_WIDTH-1:0] wr_d;
  logic                  we_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  step_s1_q;
  logic                  step_s2_q;
  logic                  step_s3_q;
  logic                  step_rise;
  logic                  advance;
  logic                  last_word;
`ifdef MEM_RMW_VERIFY_EN
  logic                  vcnt_q;
  logic                  vpend_q;
  logic                  error_q;
`endif

  function automatic logic [DATA_WIDTH-1:0] modify(input logic [1:0] m,
                                                   input logic [DATA_WIDTH-1:0] v);
    case (m)
      2'd0:    modify = v + INC_W;
      2'd1:    modify = ~v;
      2'd2:    modify = {v[DATA_WIDTH-2:0], 1'b0};
      default: modify = v;
    endcase
  endfunction

  // Two-flop synchronizer plus one edge-detect stage on the debounced button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
    end else begin
      step_s1_q <= step_i;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
    end
  end

  assign step_rise   = step_s2_q & ~step_s3_q;
  assign advance     = auto_run_i | step_rise;
  assign next_addr_d = cur_addr_q + ADDR_WIDTH'(1);
  assign wr_d        = modify(mode_q, rd_q);
  assign last_word   = (cur_addr_q == end_addr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      mode_q     <= 2'd0;
      rd_q       <= '0;
      wr_q       <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MEM_RMW_VERIFY_EN
      vcnt_q     <= 1'b0;
      vpend_q    <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE: if (advance) begin
          state_q    <= S_READ;
          cur_addr_q <= start_addr_i;
          end_addr_q <= end_addr_i;
          mode_q     <= mode_i;
          busy_q     <= 1'b1;
        end
        S_READ: if (advance) state_q <= S_WAIT;
        S_WAIT: if (advance) begin
          state_q <= S_MODIFY;
          rd_q    <= mem.mem_rdata;
        end
        // The strobe is raised only on entry, so dwelling in WRITE cannot re-write.
        S_MODIFY: if (advance) begin
          state_q <= S_WRITE;
          wr_q    <= wr_d;
          we_q    <= (mode_q != 2'd3);
        end
        S_WRITE: if (advance) begin
`ifdef MEM_RMW_VERIFY_EN
          state_q <= S_VERIFY;
          vcnt_q  <= 1'b0;
          vpend_q <= 1'b0;
`else
          state_q <= S_NEXT;
`endif
        end
`ifdef MEM_RMW_VERIFY_EN
        // First clock lets the post-write read land; an early advance is remembered.
        S_VERIFY: begin
          if (!vcnt_q) begin
            vcnt_q <= 1'b1;
            if (advance) vpend_q <= 1'b1;
          end else if (advance || vpend_q) begin
            state_q <= S_NEXT;
            vpend_q <= 1'b0;
            if ((mode_q != 2'd3) && (mem.mem_rdata != wr_q)) error_q <= 1'b1;
          end
        end
`endif
        S_NEXT: if (advance) begin
          if (last_word) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_READ;
            cur_addr_q <= next_addr_d;
          end
        end
        S_DONE: if (advance) begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_addr  = cur_addr_q;
  assign mem.mem_wdata = wr_q;
  assign mem.mem_we    = we_q;
  assign disp_addr_o   = cur_addr_q;
  assign disp_rdata_o  = rd_q;
  assign disp_wdata_o  = wr_q;
  assign state_o       = state_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
`ifdef MEM_RMW_VERIFY_EN
  assign error_o       = error_q;
`else
  assign error_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rmw_sequencer.sv
// Scoreboard bench for mem_rmw_sequencer: expected states and writes are queued, a monitor checks them.
module tb_mem_rmw_sequencer;
  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          step, auto_run;
  logic [AW-1:0] start_addr, end_addr;
  logic [1:0]    mode;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata, disp_wdata;
  logic [2:0]    state;
  logic          busy, done, error;

  always #5 clk = ~clk;

  mem_rmw_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  mem_rmw_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INC(2)) dut (
    .clk(clk), .reset(reset), .step_i(step), .auto_run_i(auto_run),
    .start_addr_i(start_addr), .end_addr_i(end_addr), .mode_i(mode),
    .mem(mif), .disp_addr_o(disp_addr), .disp_rdata_o(disp_rdata),
    .disp_wdata_o(disp_wdata), .state_o(state), .busy_o(busy),
    .done_o(done), .error_o(error)
  );

  // RAM model: synchronous read-first, optional dropped writes to address 3.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          poke_en, fill_en, drop_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= poke_data;
    end else if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (mif.mem_we && !(drop_en && mif.mem_addr == 3)) begin
      ram[mif.mem_addr] <= mif.mem_wdata;
    end
    mif.mem_rdata <= ram[mif.mem_addr];
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t        wq[$];
  logic [2:0] sq[$];
  int         checks = 0, failures = 0, we_cnt = 0;
  logic [2:0] prev_st = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every state change and every write strobe is matched against the queues.
  always @(negedge clk) begin
    wr_t w;
    if (state !== prev_st) begin
      if (sq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_state: got %0d after %0d with nothing expected", state, prev_st);
      end else begin
        chk("state_seq", {29'd0, state}, {29'd0, sq.pop_front()});
      end
      prev_st = state;
    end
    if (mif.mem_we === 1'b1) begin
      we_cnt++;
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", mif.mem_addr, mif.mem_wdata);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", {16'd0, mif.mem_addr}, {16'd0, w.a});
        chk("wr_data", {16'd0, mif.mem_wdata}, {16'd0, w.d});
      end
    end
  end

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wq.push_back(w);
  endtask

  task automatic push_sweep(input int nwords);
    for (int w = 0; w < nwords; w++) begin
      sq.push_back(3'd1); sq.push_back(3'd2); sq.push_back(3'd3); sq.push_back(3'd4);
`ifdef MEM_RMW_VERIFY_EN
      sq.push_back(3'd5);
`endif
      sq.push_back(3'd6);
    end
    sq.push_back(3'd7); sq.push_back(3'd0);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(posedge clk); #1 poke_en = 1'b0;
  endtask

  task automatic pulse(input int hi);
    step = 1'b1;
    repeat (hi) @(posedge clk);
    #1 step = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, state === s}, 32'd1);
  endtask

  task automatic run_auto(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [1:0] m,
                          input string name);
    start_addr = s; end_addr = e; mode = m;
    @(negedge clk);
    auto_run = 1'b1;
    wait_state(3'd7, 600, {name, "_reach_done"});
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_busy_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    auto_run = 1'b0;
    chk({name, "_idle"}, {29'd0, state}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] man_list[$];
    int         wbase;
    logic       found, e2, e3;
    int         n;

    reset = 1'b1; step = 1'b0; auto_run = 1'b0;
    start_addr = '0; end_addr = '0; mode = 2'd0;
    poke_en = 1'b0; fill_en = 1'b0; drop_en = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_we", {31'd0, mif.mem_we}, 32'd0);
    chk("rst_addr", {16'd0, disp_addr}, 32'd0);
    chk("rst_rdata", {16'd0, disp_rdata}, 32'd0);
    chk("rst_wdata", {16'd0, disp_wdata}, 32'd0);
    poke_data = 16'h00FF; fill_en = 1'b1;
    @(posedge clk); #1 fill_en = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Manual single word at address 5, mode 0.
    poke(16'd5, 16'h0010);
    start_addr = 16'd5; end_addr = 16'd5; mode = 2'd0;
    push_wr(16'd5, 16'h0012);
    push_sweep(1);
    man_list = '{3'd1, 3'd2, 3'd3, 3'd4,
`ifdef MEM_RMW_VERIFY_EN
                 3'd5,
`endif
                 3'd6, 3'd7, 3'd0};
    wbase = we_cnt;
    step = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("step_latency_early", {29'd0, state}, 32'd0);
    @(posedge clk); #1;
    chk("step_latency", {29'd0, state}, 32'd1);
    repeat (30) @(posedge clk);
    #1 step = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("held_step_one_advance", {29'd0, state}, 32'd1);
    for (int i = 1; i < man_list.size(); i++) begin
      pulse(2);
      chk("man_state", {29'd0, state}, {29'd0, man_list[i]});
      chk("man_busy", {31'd0, busy}, {31'd0, man_list[i] != 3'd0 && man_list[i] != 3'd7});
      chk("man_done", {31'd0, done}, {31'd0, man_list[i] == 3'd7});
      if (man_list[i] == 3'd4) begin
        repeat (20) @(posedge clk);
        #1;
        chk("dwell_one_write", we_cnt - wbase, 32'd1);
        chk("man_rdata", {16'd0, disp_rdata}, 32'h0010);
        chk("man_wdata", {16'd0, disp_wdata}, 32'h0012);
        chk("man_addr", {16'd0, disp_addr}, 32'd5);
      end
    end
    chk("man_ram5", {16'd0, ram[16'd5]}, 32'h0012);
    chk("man_we_total", we_cnt - wbase, 32'd1);

    // Auto wrap-around sweep, invert mode.
    wbase = we_cnt;
    push_wr(16'hFFFE, 16'hFF00); push_wr(16'hFFFF, 16'hFF00);
    push_wr(16'h0000, 16'hFF00); push_wr(16'h0001, 16'hFF00);
    push_sweep(4);
    run_auto(16'hFFFE, 16'h0001, 2'd1, "wrap");
    chk("wrap_fffe", {16'd0, ram[16'hFFFE]}, 32'hFF00);
    chk("wrap_ffff", {16'd0, ram[16'hFFFF]}, 32'hFF00);
    chk("wrap_0000", {16'd0, ram[16'h0000]}, 32'hFF00);
    chk("wrap_0001", {16'd0, ram[16'h0001]}, 32'hFF00);
    chk("wrap_fffd_untouched", {16'd0, ram[16'hFFFD]}, 32'h00FF);
    chk("wrap_0002_untouched", {16'd0, ram[16'h0002]}, 32'h00FF);
    chk("wrap_we_count", we_cnt - wbase, 32'd4);

    // Shift-left mode drops the MSB.
    poke(16'h0010, 16'h8001);
    push_wr(16'h0010, 16'h0002);
    push_sweep(1);
    run_auto(16'h0010, 16'h0010, 2'd2, "shl");
    chk("shl_ram", {16'd0, ram[16'h0010]}, 32'h0002);

    // Add mode wraps without carry.
    poke(16'h0030, 16'hFFFF);
    push_wr(16'h0030, 16'h0001);
    push_sweep(1);
    run_auto(16'h0030, 16'h0030, 2'd0, "addwrap");
    chk("addwrap_ram", {16'd0, ram[16'h0030]}, 32'h0001);

    // Read-only mode: no strobe, write register mirrors the read.
    poke(16'h0020, 16'h1234);
    wbase = we_cnt;
    push_sweep(1);
    run_auto(16'h0020, 16'h0020, 2'd3, "ro");
    chk("ro_ram", {16'd0, ram[16'h0020]}, 32'h1234);
    chk("ro_no_we", we_cnt - wbase, 32'd0);
    chk("ro_wdata", {16'd0, disp_wdata}, 32'h1234);
    chk("ro_rdata", {16'd0, disp_rdata}, 32'h1234);

    // Reset lands on the first WRITE clock of a 3-word sweep.
    poke(16'h0040, 16'h0100); poke(16'h0041, 16'h0100); poke(16'h0042, 16'h0100);
    start_addr = 16'h0040; end_addr = 16'h0042; mode = 2'd0;
    sq.push_back(3'd1); sq.push_back(3'd2); sq.push_back(3'd3); sq.push_back(3'd0);
    wbase = we_cnt;
    found = 1'b0;
    auto_run = 1'b1;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (state == 3'd4) found = 1'b1;
    end
    reset = 1'b1; auto_run = 1'b0;
    #1;
    chk("rst_mid_found_write", {31'd0, found}, 32'd1);
    chk("rst_mid_we", {31'd0, mif.mem_we}, 32'd0);
    chk("rst_mid_state", {29'd0, state}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_ram40", {16'd0, ram[16'h0040]}, 32'h0100);
    chk("rst_mid_ram41", {16'd0, ram[16'h0041]}, 32'h0100);
    chk("rst_mid_ram42", {16'd0, ram[16'h0042]}, 32'h0100);
    chk("rst_mid_no_we", we_cnt - wbase, 32'd0);
    chk("rst_mid_still_idle", {29'd0, state}, 32'd0);

    // Writes to address 3 are dropped by the RAM model.
    poke(16'd2, 16'h0007); poke(16'd3, 16'h0007); poke(16'd4, 16'h0007);
    drop_en = 1'b1;
    push_wr(16'd2, 16'h0009); push_wr(16'd3, 16'h0009); push_wr(16'd4, 16'h0009);
    push_sweep(3);
    start_addr = 16'd2; end_addr = 16'd4; mode = 2'd0;
    e2 = 1'bx; e3 = 1'bx; n = 0;
    @(negedge clk);
    auto_run = 1'b1;
    while (state !== 3'd7 && n < 600) begin
      @(negedge clk);
      n++;
      if (state == 3'd6 && disp_addr == 16'd2) e2 = error;
      if (state == 3'd6 && disp_addr == 16'd3) e3 = error;
    end
    chk("err_reach_done", {31'd0, state === 3'd7}, 32'd1);
    chk("err_after_addr2", {31'd0, e2}, 32'd0);
`ifdef MEM_RMW_VERIFY_EN
    chk("err_after_addr3", {31'd0, e3}, 32'd1);
    chk("err_at_done", {31'd0, error}, 32'd1);
`else
    chk("err_after_addr3", {31'd0, e3}, 32'd0);
    chk("err_at_done", {31'd0, error}, 32'd0);
`endif
    @(negedge clk);
    auto_run = 1'b0;
    chk("err_idle", {29'd0, state}, 32'd0);
`ifdef MEM_RMW_VERIFY_EN
    chk("err_sticky", {31'd0, error}, 32'd1);
`else
    chk("err_sticky", {31'd0, error}, 32'd0);
`endif
    drop_en = 1'b0;
    chk("err_ram4", {16'd0, ram[16'd4]}, 32'h0009);
    repeat (4) @(posedge clk);
    #1;
    chk("sq_empty", sq.size(), 32'd0);
    chk("wq_empty", wq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
